// File: rtl/truth_table_sequencer.sv
// -----------------------------------------------------------------------------
// truth_table_sequencer
//
// Walks one shared 3-input boolean evaluator through all eight input
// combinations for every function selected in fn_mask, one function at a
// time, and captures each function's 8-bit truth table.
//
// Ports
//   clk       in   1      clock, rising edge
//   reset     in   1      synchronous, active-high
//   start     in   1      begin a run (honoured only while idle)
//   fn_mask   in   NFUNC  functions to scan; sampled together with start
//   fn_sel    out  3      function currently selected onto the evaluator mux
//   x,y,z     out  1 ea   evaluator inputs (registered), {x,y,z} = combo index
//   s_in      in   1      evaluator output for fn_sel
//   busy      out  1      high whenever the controller is not idle
//   done      out  1      one-cycle pulse at the end of a run
//   valid     out  NFUNC  bit i: table i is complete and current
//   rd_sel    in   3      table read select
//   rd_table  out  8      table[rd_sel], 8'h00 when rd_sel >= NFUNC
// -----------------------------------------------------------------------------
module truth_table_sequencer #(
    parameter int NFUNC  = 5,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NFUNC-1:0] fn_mask,
    output logic [2:0]       fn_sel,
    output logic             x,
    output logic             y,
    output logic             z,
    input  logic             s_in,
    output logic             busy,
    output logic             done,
    output logic [NFUNC-1:0] valid,
    input  logic [2:0]       rd_sel,
    output logic [7:0]       rd_table
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_APPLY,
        S_SAMPLE,
        S_DONE
    } state_t;

    // Settle counter counts 0..SETTLE-1 while in APPLY.
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    state_t           state_q, state_d;
    logic [NFUNC-1:0] pending_q, pending_d;
    logic [2:0]       fn_sel_q, fn_sel_d;
    logic [2:0]       c_q, c_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [2:0]       xyz_q, xyz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [NFUNC-1:0] valid_q, valid_d;
    logic [2:0]       low_idx;
    logic [NFUNC*8-1:0] tables_flat;

    // Index of the lowest pending function (only meaningful when pending != 0).
    always_comb begin
        low_idx = 3'd0;
        for (int i = NFUNC - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_idx = 3'(i);
            end
        end
    end

    // Next-state and registered-output logic for the controller.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        fn_sel_d  = fn_sel_q;
        c_d       = c_q;
        settle_d  = settle_q;
        xyz_d     = xyz_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        valid_d   = valid_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pending_d = fn_mask;
                    valid_d   = valid_q & ~fn_mask;
                    busy_d    = 1'b1;
                    state_d   = S_SEL;
                end
            end
            S_SEL: begin
                if (pending_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    fn_sel_d  = low_idx;
                    // Clearing the lowest set bit: p & (p - 1).
                    pending_d = pending_q & (pending_q - 1'b1);
                    c_d       = 3'd0;
                    settle_d  = '0;
                    xyz_d     = 3'd0;
                    state_d   = S_APPLY;
                end
            end
            S_APPLY: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                if (c_q != 3'd7) begin
                    c_d      = c_q + 3'd1;
                    xyz_d    = c_q + 3'd1;
                    settle_d = '0;
                    state_d  = S_APPLY;
                end else begin
                    for (int i = 0; i < NFUNC; i++) begin
                        if (fn_sel_q == 3'(i)) begin
                            valid_d[i] = 1'b1;
                        end
                    end
                    xyz_d   = 3'd0;
                    state_d = S_SEL;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                xyz_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            fn_sel_q  <= 3'd0;
            c_q       <= 3'd0;
            settle_q  <= '0;
            xyz_q     <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            fn_sel_q  <= fn_sel_d;
            c_q       <= c_d;
            settle_q  <= settle_d;
            xyz_q     <= xyz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
        end
    end

    // One 8-bit table register per function; bit c captures s_in for combo c
    // at the end of the SAMPLE cycle.
    generate
        for (genvar gi = 0; gi < NFUNC; gi++) begin : gen_tbl
            logic [7:0] tbl_q, tbl_d;

            always_comb begin
                tbl_d = tbl_q;
                if (state_q == S_SAMPLE && fn_sel_q == 3'(gi)) begin
                    tbl_d[c_q] = s_in;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    tbl_q <= 8'h00;
                end else begin
                    tbl_q <= tbl_d;
                end
            end

            assign tables_flat[gi*8 +: 8] = tbl_q;
        end
    endgenerate

    // Read port; out-of-range selects read as zero.
    always_comb begin
        rd_table = 8'h00;
        for (int i = 0; i < NFUNC; i++) begin
            if (rd_sel == 3'(i)) begin
                rd_table = tables_flat[i*8 +: 8];
            end
        end
    end

    assign fn_sel = fn_sel_q;
    assign x      = xyz_q[2];
    assign y      = xyz_q[1];
    assign z      = xyz_q[0];
    assign busy   = busy_q;
    assign done   = done_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sequencer
//
// Two instances: dut (SETTLE=1) and dut3 (SETTLE=3). Each evaluator is modelled
// as a lookup into fn_tab. Expected tables/valid are tracked in exp_tab /
// exp_valid, and the expected done cycle comes from the run-length formula.
// -----------------------------------------------------------------------------
module tb_truth_table_sequencer;

    localparam int NF = 5;
    localparam int MAXC = 256;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          start3 = 1'b0;
    logic [NF-1:0] fn_mask = '0;
    logic [2:0]    rd_sel = 3'd0;

    logic [2:0]    fn_sel, fn_sel3;
    logic          x, y, z, x3, y3, z3;
    logic          s_in, s_in3;
    logic          busy, done, busy3, done3;
    logic [NF-1:0] valid, valid3;
    logic [7:0]    rd_table, rd_table3;

    logic [7:0]    fn_tab [NF];
    logic [7:0]    exp_tab [NF];
    logic [NF-1:0] exp_valid;

    logic [2:0]    log_xyz   [MAXC];
    logic          log_busy  [MAXC];
    logic          log_done  [MAXC];
    logic [NF-1:0] log_valid [MAXC];
    logic [2:0]    log_fsel  [MAXC];

    int checks = 0;
    int failures = 0;

    truth_table_sequencer #(.NFUNC(NF), .SETTLE(1)) dut (
        .clk(clk), .reset(reset), .start(start), .fn_mask(fn_mask),
        .fn_sel(fn_sel), .x(x), .y(y), .z(z), .s_in(s_in),
        .busy(busy), .done(done), .valid(valid),
        .rd_sel(rd_sel), .rd_table(rd_table)
    );

    truth_table_sequencer #(.NFUNC(NF), .SETTLE(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .fn_mask(fn_mask),
        .fn_sel(fn_sel3), .x(x3), .y(y3), .z(z3), .s_in(s_in3),
        .busy(busy3), .done(done3), .valid(valid3),
        .rd_sel(rd_sel), .rd_table(rd_table3)
    );

    always #5 clk = ~clk;

    // Behavioural evaluators: function i's truth table looked up by {x,y,z}.
    always_comb begin
        s_in = 1'b0;
        for (int i = 0; i < NF; i++) begin
            if (fn_sel == 3'(i)) s_in = fn_tab[i][{x, y, z}];
        end
    end

    always_comb begin
        s_in3 = 1'b0;
        for (int i = 0; i < NF; i++) begin
            if (fn_sel3 == 3'(i)) s_in3 = fn_tab[i][{x3, y3, z3}];
        end
    end

    task automatic set_default_fns();
        fn_tab[0] = 8'h70;
        fn_tab[1] = 8'h08;
        fn_tab[2] = 8'h51;
        fn_tab[3] = 8'h54;
        fn_tab[4] = 8'hDC;
    endtask

    // Model update after a completed run.
    task automatic model_run(input logic [NF-1:0] mask);
        for (int i = 0; i < NF; i++) begin
            if (mask[i]) begin
                exp_tab[i]   = fn_tab[i];
                exp_valid[i] = 1'b1;
            end
        end
    endtask

    function automatic int exp_done_cycle(input logic [NF-1:0] mask, input int settle);
        return $countones(mask) * (1 + 8 * (settle + 1)) + 2;
    endfunction

    // Launch a run (start accepted at edge 0) and log outputs at the negedge
    // of each following cycle. Optional start pulse / reset during the run.
    task automatic run(input bit use3, input logic [NF-1:0] mask,
                       input int pulse_cyc, input int rst_cyc,
                       output int done_cyc, output int ndone);
        int cyc;
        @(negedge clk);
        fn_mask = mask;
        if (use3) start3 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start3 = 1'b0;
        fn_mask = NF'($urandom);
        cyc = 1;
        done_cyc = -1;
        ndone = 0;
        while (cyc < MAXC - 1) begin
            log_xyz[cyc]   = use3 ? {x3, y3, z3} : {x, y, z};
            log_busy[cyc]  = use3 ? busy3 : busy;
            log_done[cyc]  = use3 ? done3 : done;
            log_valid[cyc] = use3 ? valid3 : valid;
            log_fsel[cyc]  = use3 ? fn_sel3 : fn_sel;
            if (log_done[cyc]) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (rst_cyc > 0 && cyc == rst_cyc + 1) break;
            if (done_cyc > 0 && cyc >= done_cyc + 3) break;
            start = (cyc == pulse_cyc);
            reset = (rst_cyc > 0 && cyc == rst_cyc);
            fn_mask = NF'($urandom);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy_done: busy=%b done=%b required 0 0", busy, done);
        end
        checks++;
        if ({x, y, z} !== 3'b000 || fn_sel !== 3'd0) begin
            failures++;
            $display("FAIL reset_xyz_fnsel: xyz=%b fn_sel=%0d required 000 0", {x, y, z}, fn_sel);
        end
        checks++;
        if (valid !== '0) begin
            failures++;
            $display("FAIL reset_valid: got %b required 00000", valid);
        end
        for (int s = 0; s < 8; s++) begin
            rd_sel = 3'(s);
            #1;
            checks++;
            if (rd_table !== 8'h00) begin
                failures++;
                $display("FAIL reset_table%0d: got %h required 00", s, rd_table);
            end
        end
        for (int i = 0; i < NF; i++) exp_tab[i] = 8'h00;
        exp_valid = '0;
    endtask

    task automatic test_full_scan();
        int dc, nd;
        run(1'b0, 5'b11111, 0, 0, dc, nd);
        model_run(5'b11111);
        $display("full_scan: done_cycle=%0d ndone=%0d valid=%b", dc, nd, valid);
        checks++;
        if (dc != 87 || nd != 1) begin
            failures++;
            $display("FAIL full_done: cycle=%0d count=%0d required cycle 87 count 1", dc, nd);
        end
        checks++;
        if (valid !== 5'b11111) begin
            failures++;
            $display("FAIL full_valid: got %b required 11111", valid);
        end
        for (int s = 0; s < NF; s++) begin
            rd_sel = 3'(s);
            #1;
            checks++;
            if (rd_table !== exp_tab[s]) begin
                failures++;
                $display("FAIL full_table%0d: got %h required %h", s, rd_table, exp_tab[s]);
            end
        end
    endtask

    task automatic test_single();
        int dc, nd, bad;
        // start also pulsed during the DONE cycle (19): must be ignored
        run(1'b0, 5'b00100, 19, 0, dc, nd);
        model_run(5'b00100);
        $display("single: done_cycle=%0d ndone=%0d", dc, nd);
        checks++;
        if (dc != 19 || nd != 1) begin
            failures++;
            $display("FAIL single_done: cycle=%0d count=%0d required cycle 19 count 1", dc, nd);
        end
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            if (log_xyz[2 + 2*c] !== 3'(c) || log_xyz[3 + 2*c] !== 3'(c)) bad++;
            if (log_fsel[2 + 2*c] !== 3'd2) bad++;
        end
        if (log_xyz[1] !== 3'd0 || log_xyz[18] !== 3'd0 || log_xyz[19] !== 3'd0) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL single_xyz_seq: %0d bad cycles required 0", bad);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle_after: busy=%b required 0", busy);
        end
        rd_sel = 3'd2;
        #1;
        checks++;
        if (rd_table !== 8'h51) begin
            failures++;
            $display("FAIL single_table2: got %h required 51", rd_table);
        end
    endtask

    task automatic test_empty();
        int dc, nd;
        run(1'b0, 5'b00000, 0, 0, dc, nd);
        $display("empty: done_cycle=%0d busy1=%b busy2=%b busy3=%b", dc, log_busy[1], log_busy[2], log_busy[3]);
        checks++;
        if (dc != 2 || nd != 1) begin
            failures++;
            $display("FAIL empty_done: cycle=%0d count=%0d required cycle 2 count 1", dc, nd);
        end
        checks++;
        if (log_busy[1] !== 1'b1 || log_busy[2] !== 1'b1 || log_busy[3] !== 1'b0) begin
            failures++;
            $display("FAIL empty_busy: %b%b%b required 110", log_busy[1], log_busy[2], log_busy[3]);
        end
        checks++;
        if (valid !== exp_valid) begin
            failures++;
            $display("FAIL empty_valid: got %b required %b", valid, exp_valid);
        end
        for (int s = 0; s < NF; s++) begin
            rd_sel = 3'(s);
            #1;
            checks++;
            if (rd_table !== exp_tab[s]) begin
                failures++;
                $display("FAIL empty_table%0d: got %h required %h", s, rd_table, exp_tab[s]);
            end
        end
    endtask

    task automatic test_partial_rerun();
        int dc, nd;
        run(1'b0, 5'b00010, 5, 0, dc, nd);
        model_run(5'b00010);
        $display("partial: done_cycle=%0d ndone=%0d valid_mid=%b valid_end=%b", dc, nd, log_valid[3], valid);
        checks++;
        if (log_valid[3] !== 5'b11101 || log_valid[10] !== 5'b11101) begin
            failures++;
            $display("FAIL partial_valid_mid: got %b required 11101", log_valid[3]);
        end
        checks++;
        if (dc != 19 || nd != 1) begin
            failures++;
            $display("FAIL partial_done: cycle=%0d count=%0d required cycle 19 count 1", dc, nd);
        end
        checks++;
        if (valid !== 5'b11111) begin
            failures++;
            $display("FAIL partial_valid_end: got %b required 11111", valid);
        end
    endtask

    task automatic test_random();
        int dc, nd;
        logic [NF-1:0] mask;
        logic [NF-1:0] vbefore;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < NF; i++) fn_tab[i] = 8'($urandom);
            mask = NF'($urandom_range(0, 31));
            vbefore = exp_valid & ~mask;
            run(1'b0, mask, 0, 0, dc, nd);
            model_run(mask);
            $display("random%0d: mask=%b done_cycle=%0d ndone=%0d valid=%b", it, mask, dc, nd, valid);
            checks++;
            if (dc != exp_done_cycle(mask, 1) || nd != 1) begin
                failures++;
                $display("FAIL rand_done: cycle=%0d count=%0d required cycle %0d count 1",
                         dc, nd, exp_done_cycle(mask, 1));
            end
            checks++;
            if (log_valid[1] !== vbefore || valid !== exp_valid) begin
                failures++;
                $display("FAIL rand_valid: start=%b end=%b required %b %b", log_valid[1], valid, vbefore, exp_valid);
            end
            for (int s = 0; s < 8; s++) begin
                rd_sel = 3'(s);
                #1;
                checks++;
                if (rd_table !== ((s < NF) ? exp_tab[s] : 8'h00)) begin
                    failures++;
                    $display("FAIL rand_table%0d: got %h required %h", s, rd_table,
                             (s < NF) ? exp_tab[s] : 8'h00);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int dc, nd;
        set_default_fns();
        run(1'b0, 5'b11111, 0, 40, dc, nd);
        reset = 1'b0;
        $display("reset_mid: ndone=%0d busy=%b valid=%b xyz=%b", nd, busy, valid, {x, y, z});
        checks++;
        if (nd != 0 || log_busy[40] !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_nodone: done count=%0d busy40=%b required 0 1", nd, log_busy[40]);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || {x, y, z} !== 3'b000 || valid !== '0) begin
            failures++;
            $display("FAIL rstmid_state: busy=%b done=%b xyz=%b valid=%b required 0 0 000 00000",
                     busy, done, {x, y, z}, valid);
        end
        for (int i = 0; i < NF; i++) exp_tab[i] = 8'h00;
        exp_valid = '0;
        for (int s = 0; s < 8; s++) begin
            rd_sel = 3'(s);
            #1;
            checks++;
            if (rd_table !== 8'h00) begin
                failures++;
                $display("FAIL rstmid_table%0d: got %h required 00", s, rd_table);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_after: done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_settle3();
        int dc, nd;
        set_default_fns();
        run(1'b1, 5'b11111, 0, 0, dc, nd);
        $display("settle3: done_cycle=%0d ndone=%0d valid=%b", dc, nd, valid3);
        checks++;
        if (dc != 167 || nd != 1) begin
            failures++;
            $display("FAIL s3_done: cycle=%0d count=%0d required cycle 167 count 1", dc, nd);
        end
        checks++;
        if (valid3 !== 5'b11111) begin
            failures++;
            $display("FAIL s3_valid: got %b required 11111", valid3);
        end
        for (int s = 0; s < NF; s++) begin
            rd_sel = 3'(s);
            #1;
            checks++;
            if (rd_table3 !== fn_tab[s]) begin
                failures++;
                $display("FAIL s3_table%0d: got %h required %h", s, rd_table3, fn_tab[s]);
            end
        end
    endtask

    initial begin
        set_default_fns();
        test_reset();
        test_full_scan();
        test_single();
        test_empty();
        test_partial_rerun();
        test_random();
        test_reset_mid_run();
        test_settle3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
